// File: rtl/flash_pic_loader.sv
// -----------------------------------------------------------------------------
// flash_pic_loader
//   Fetches one frame of RGB565 pixels from SPI flash (mode 0) with a single
//   continuous READ and streams them as 16-bit words into the SDRAM write path.
//
//   Build option: define FLASH_FAST_READ_EN to use FAST READ (0x0B) with a
//   40-bit header {0x0B, START_ADDR, 8'h00 dummy}. Default is READ (0x03) with
//   a 32-bit header {0x03, START_ADDR}.
//
//   Ports:
//     clk, rst            system clock, synchronous active-high reset
//     sdram_init_done     level; the transfer starts the first cycle it is seen
//     flash_clk/cs        SPI SCK (idle low) and active-low chip select
//     flash_datain        MOSI, changes only when SCK falls
//     flash_dataout       MISO, sampled on the cycle SCK rises
//     mydata_o/myvalid_o  packed word plus one-cycle strobe; no backpressure,
//                         the consumer must take every strobed word
//     frame_write_done    sticky once every word has been emitted
//     busy                high while the flash transaction is in progress
// -----------------------------------------------------------------------------
module flash_pic_loader #(
   parameter logic [23:0] START_ADDR = 24'h000000,
   parameter int unsigned WORD_CNT   = 130560,
   parameter int unsigned CLK_DIV    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sdram_init_done,
   output logic        flash_clk,
   output logic        flash_cs,
   output logic        flash_datain,
   input  logic        flash_dataout,
   output logic [15:0] mydata_o,
   output logic        myvalid_o,
   output logic        frame_write_done,
   output logic        busy
);

`ifdef FLASH_FAST_READ_EN
   localparam int unsigned HDR_BITS = 40;
   localparam logic [HDR_BITS-1:0] HDR_WORD = {8'h0B, START_ADDR, 8'h00};
`else
   localparam int unsigned HDR_BITS = 32;
   localparam logic [HDR_BITS-1:0] HDR_WORD = {8'h03, START_ADDR};
`endif

   localparam int unsigned WCNT_W = ($clog2(WORD_CNT + 1) > 18) ? $clog2(WORD_CNT + 1) : 18;
   localparam int unsigned DIV_W  = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORD_CNT);
   localparam logic [5:0]        HDR_LAST  = 6'(HDR_BITS);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CS_SETUP = 3'd1,
      CMD      = 3'd2,
      DATA     = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic                sck_q, sck_d;
   logic                cs_q, cs_d;
   logic                mosi_q, mosi_d;
   logic [HDR_BITS-1:0] hdr_q, hdr_d;
   logic [5:0]          bit_q, bit_d;
   logic [15:0]         rx_q, rx_d;
   logic                pend_q, pend_d;
   logic [15:0]         data_q, data_d;
   logic                valid_q, valid_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;

   logic tick, rise_evt, fall_evt;

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      sck_d    = sck_q;
      cs_d     = cs_q;
      mosi_d   = mosi_q;
      hdr_d    = hdr_q;
      bit_d    = bit_q;
      rx_d     = rx_q;
      pend_d   = 1'b0;
      data_d   = data_q;
      valid_d  = 1'b0;
      wcnt_d   = wcnt_q;
      done_d   = done_q;

      // An SCK half-period ends on the last divider count; the edge it produces
      // is a rising event when SCK is currently low, a falling one otherwise.
      tick     = (div_q == DIV_LAST);
      rise_evt = tick && !sck_q;
      fall_evt = tick && sck_q;

      case (state_q)
         IDLE: begin
            if (sdram_init_done) begin
               state_d = CS_SETUP;
               cs_d    = 1'b0;
               mosi_d  = HDR_WORD[HDR_BITS-1];
               hdr_d   = HDR_WORD;
               div_d   = '0;
               bit_d   = '0;
            end
         end

         CS_SETUP: begin
            if (tick) begin
               state_d = CMD;
               div_d   = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         CMD: begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) sck_d = !sck_q;
            if (rise_evt) bit_d = bit_q + 1'b1;
            if (fall_evt) begin
               // bit_q counts header bits already clocked into the flash.
               if (bit_q == HDR_LAST) begin
                  state_d = DATA;
                  mosi_d  = 1'b0;
                  bit_d   = '0;
               end else begin
                  hdr_d  = hdr_q << 1;
                  mosi_d = hdr_q[HDR_BITS-2];
               end
            end
         end

         DATA: begin
            // Word assembled on the previous cycle's rising event goes out now.
            if (pend_q) begin
               data_d  = rx_q;
               valid_d = 1'b1;
               wcnt_d  = wcnt_q + 1'b1;
            end
            // Once the last word is out, finish as soon as SCK is low again,
            // without starting another SCK pulse.
            if ((wcnt_q == WCNT_LAST) && (!sck_q || fall_evt)) begin
               state_d = DONE;
               cs_d    = 1'b1;
               sck_d   = 1'b0;
               done_d  = 1'b1;
               div_d   = '0;
            end else begin
               div_d = tick ? '0 : div_q + 1'b1;
               if (tick) sck_d = !sck_q;
               if (rise_evt) begin
                  rx_d = {rx_q[14:0], flash_dataout};
                  if (bit_q == 6'd15) begin
                     bit_d  = '0;
                     pend_d = 1'b1;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end
            end
         end

         DONE: begin
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d == CS_SETUP) || (state_d == CMD) || (state_d == DATA);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         sck_q   <= 1'b0;
         cs_q    <= 1'b1;
         mosi_q  <= 1'b0;
         hdr_q   <= '0;
         bit_q   <= '0;
         rx_q    <= '0;
         pend_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         wcnt_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         sck_q   <= sck_d;
         cs_q    <= cs_d;
         mosi_q  <= mosi_d;
         hdr_q   <= hdr_d;
         bit_q   <= bit_d;
         rx_q    <= rx_d;
         pend_q  <= pend_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         wcnt_q  <= wcnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign flash_clk        = sck_q;
   assign flash_cs         = cs_q;
   assign flash_datain     = mosi_q;
   assign mydata_o         = data_q;
   assign myvalid_o        = valid_q;
   assign frame_write_done = done_q;
   assign busy             = busy_q;

endmodule

// File: tb/tb_flash_pic_loader.sv
// -----------------------------------------------------------------------------
// tb_flash_pic_loader
//   Two loader instances with different parameters share one clock:
//     lane 0: START_ADDR=0x000000, WORD_CNT=4, CLK_DIV=1
//     lane 1: START_ADDR=0x123456, WORD_CNT=1, CLK_DIV=3
//   A per-lane flash model answers the READ with bytes 12 34 56 78 9A BC DE F0.
// -----------------------------------------------------------------------------
module tb_flash_pic_loader;
   localparam int NL = 2;
`ifdef FLASH_FAST_READ_EN
   localparam int HDR = 40;
   localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
   localparam int HDR = 32;
   localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

   logic clk = 1'b0;
   initial forever #5 clk = ~clk;

   logic [NL-1:0] rst_v;
   logic [NL-1:0] init_v;
   logic [NL-1:0] miso_v;
   wire  [NL-1:0] sck_v, cs_v, mosi_v, valid_v, done_v, busy_v;
   wire  [15:0]   data0, data1;

   flash_pic_loader #(.START_ADDR(24'h000000), .WORD_CNT(4), .CLK_DIV(1)) dut0 (
      .clk(clk), .rst(rst_v[0]), .sdram_init_done(init_v[0]),
      .flash_clk(sck_v[0]), .flash_cs(cs_v[0]), .flash_datain(mosi_v[0]),
      .flash_dataout(miso_v[0]), .mydata_o(data0), .myvalid_o(valid_v[0]),
      .frame_write_done(done_v[0]), .busy(busy_v[0]));

   flash_pic_loader #(.START_ADDR(24'h123456), .WORD_CNT(1), .CLK_DIV(3)) dut1 (
      .clk(clk), .rst(rst_v[1]), .sdram_init_done(init_v[1]),
      .flash_clk(sck_v[1]), .flash_cs(cs_v[1]), .flash_datain(mosi_v[1]),
      .flash_dataout(miso_v[1]), .mydata_o(data1), .myvalid_o(valid_v[1]),
      .frame_write_done(done_v[1]), .busy(busy_v[1]));

   // ---------------- checking bookkeeping ----------------
   int n_checks, n_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic flash_bit(input int k);
      logic [63:0] img;
      img = 64'h123456789ABCDEF0;
      return img[63 - (k % 64)];
   endfunction

   function automatic logic [15:0] lane_data(input int l);
      return (l == 0) ? data0 : data1;
   endfunction

   function automatic logic [39:0] exp_hdr(input logic [23:0] addr);
`ifdef FLASH_FAST_READ_EN
      return {CMD_BYTE, addr, 8'h00};
`else
      return {8'h00, CMD_BYTE, addr};
`endif
   endfunction

   // ---------------- monitor + flash model (negedge sampled) ----------------
   int          cyc;
   int          rise_cnt [NL], fall_cnt [NL], cs_fall_cyc [NL], first_rise_cyc [NL];
   int          last_tog [NL], half_min [NL], half_max [NL], strobe_cnt [NL];
   int          done_cyc [NL], mosi_bad [NL], wide_cnt [NL], done_fell [NL];
   int          sck_after_done [NL];
   int          strobe_cyc [NL][8];
   logic [15:0] strobe_w [NL][8];
   logic [39:0] hdr_rx [NL];
   logic [NL-1:0] p_sck, p_cs, p_mosi, p_valid, p_done;

   task automatic clear_lane(input int l);
      rise_cnt[l] = 0;        fall_cnt[l] = 0;
      cs_fall_cyc[l] = -1;    first_rise_cyc[l] = -1;
      last_tog[l] = -1;       half_min[l] = 1000000; half_max[l] = 0;
      strobe_cnt[l] = 0;      done_cyc[l] = -1;
      mosi_bad[l] = 0;        wide_cnt[l] = 0;
      done_fell[l] = 0;       sck_after_done[l] = 0;
      hdr_rx[l] = '0;
   endtask

   initial begin : monitor
      logic rise_e, fall_e;
      int   k;
      cyc = 0;
      miso_v = '0;
      p_sck = '0; p_cs = '1; p_mosi = '0; p_valid = '0; p_done = '0;
      for (int l = 0; l < NL; l++) clear_lane(l);
      forever begin
         @(negedge clk);
         cyc++;
         for (int l = 0; l < NL; l++) begin
            rise_e = !p_sck[l] && sck_v[l];
            fall_e = p_sck[l] && !sck_v[l];
            if (rst_v[l]) begin
               clear_lane(l);
            end else begin
               if (p_cs[l] && !cs_v[l]) begin
                  cs_fall_cyc[l] = cyc;
                  hdr_rx[l] = '0;
                  first_rise_cyc[l] = -1;
               end
               if (cs_v[l]) begin
                  rise_cnt[l] = 0;
                  fall_cnt[l] = 0;
                  last_tog[l] = -1;
               end else begin
                  if (rise_e) begin
                     rise_cnt[l]++;
                     if (rise_cnt[l] == 1) first_rise_cyc[l] = cyc;
                     if (rise_cnt[l] <= HDR) hdr_rx[l] = {hdr_rx[l][38:0], mosi_v[l]};
                  end
                  if (fall_e) begin
                     fall_cnt[l]++;
                     if (fall_cnt[l] >= HDR) miso_v[l] = flash_bit(fall_cnt[l] - HDR);
                  end
                  if (rise_e || fall_e) begin
                     if (last_tog[l] >= 0) begin
                        k = cyc - last_tog[l];
                        if (k < half_min[l]) half_min[l] = k;
                        if (k > half_max[l]) half_max[l] = k;
                     end
                     last_tog[l] = cyc;
                  end
               end
               if ((mosi_v[l] != p_mosi[l]) && !fall_e && (p_cs[l] == cs_v[l])) mosi_bad[l]++;
               if (valid_v[l]) begin
                  if (p_valid[l]) wide_cnt[l]++;
                  if (strobe_cnt[l] < 8) begin
                     strobe_w[l][strobe_cnt[l]]   = lane_data(l);
                     strobe_cyc[l][strobe_cnt[l]] = cyc;
                  end
                  strobe_cnt[l]++;
               end
               if (done_v[l] && done_cyc[l] < 0) done_cyc[l] = cyc;
               if (p_done[l] && !done_v[l]) done_fell[l]++;
               if (done_v[l] && p_done[l] && (rise_e || fall_e)) sck_after_done[l]++;
            end
            p_sck[l]   = sck_v[l];
            p_cs[l]    = cs_v[l];
            p_mosi[l]  = mosi_v[l];
            p_valid[l] = valid_v[l];
            p_done[l]  = done_v[l];
         end
      end
   end

   // ---------------- scenario table ----------------
   typedef struct {
      int          lane;
      int          words;
      int          div;
      int          idle_cyc;
      logic [23:0] addr;
      logic [63:0] exp_words;
   } scen_t;

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin : main
      scen_t       tbl [2];
      int          l, dv, viol, ok;
      logic [63:0] ew;
      logic [15:0] exp_w;

      n_checks = 0;
      n_err    = 0;
      rst_v    = '1;
      init_v   = '0;

      tbl[0] = '{lane: 0, words: 4, div: 1, idle_cyc: 1000, addr: 24'h000000,
                 exp_words: 64'h1234_5678_9ABC_DEF0};
      tbl[1] = '{lane: 1, words: 1, div: 3, idle_cyc: 50, addr: 24'h123456,
                 exp_words: 64'h1234_0000_0000_0000};

      repeat (3) @(posedge clk);
      #1;

      for (int s = 0; s < 2; s++) begin
         l  = tbl[s].lane;
         dv = tbl[s].div;

         rst_v[l] = 1'b1;
         @(posedge clk); #1;
         check($sformatf("L%0d reset_ctl", l),
               {58'd0, cs_v[l], sck_v[l], mosi_v[l], valid_v[l], done_v[l], busy_v[l]}, 64'b100000);
         check($sformatf("L%0d reset_data", l), {48'd0, lane_data(l)}, 64'h0);
         rst_v[l] = 1'b0;

         // Held idle while SDRAM is not ready.
         viol = 0;
         repeat (tbl[s].idle_cyc) begin
            @(posedge clk); #1;
            if (cs_v[l] !== 1'b1 || sck_v[l] !== 1'b0 || busy_v[l] !== 1'b0) viol++;
         end
         check($sformatf("L%0d idle_hold", l), viol, 0);

         init_v[l] = 1'b1;
         ok = 0;
         for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            if (rise_cnt[l] >= HDR + 4) begin ok = 1; break; end
         end
         check($sformatf("L%0d reach_data", l), ok, 1);
         // Dropping the ready level mid-frame must not disturb the transfer.
         init_v[l] = 1'b0;

         ok = 0;
         for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            if (done_v[l] === 1'b1) begin ok = 1; break; end
         end
         check($sformatf("L%0d done_seen", l), ok, 1);
         check($sformatf("L%0d done_ctl", l), {61'd0, cs_v[l], sck_v[l], busy_v[l]}, 64'b100);

         repeat (30) @(posedge clk);
         #1;
         check($sformatf("L%0d tail_ctl", l),
               {60'd0, done_v[l], cs_v[l], sck_v[l], busy_v[l]}, 64'b1100);
         check($sformatf("L%0d header", l), hdr_rx[l], exp_hdr(tbl[s].addr));
         check($sformatf("L%0d strobe_cnt", l), strobe_cnt[l], tbl[s].words);
         ew = tbl[s].exp_words;
         for (int w = 0; w < tbl[s].words; w++) begin
            exp_w = ew[63 - 16*w -: 16];
            check($sformatf("L%0d word%0d", l, w), strobe_w[l][w], exp_w);
         end
         for (int w = 1; w < tbl[s].words; w++)
            check($sformatf("L%0d gap%0d", l, w), strobe_cyc[l][w] - strobe_cyc[l][w-1], 32*dv);
         check($sformatf("L%0d first_strobe_lag", l),
               strobe_cyc[l][0] - cs_fall_cyc[l], 2*dv*HDR + 32*dv + 1);
         check($sformatf("L%0d first_rise_lag", l), first_rise_cyc[l] - cs_fall_cyc[l], 2*dv);
         check($sformatf("L%0d done_lag", l),
               done_cyc[l] - strobe_cyc[l][tbl[s].words-1], (dv == 1) ? 1 : dv - 1);
         check($sformatf("L%0d half_min", l), half_min[l], dv);
         check($sformatf("L%0d half_max", l), half_max[l], dv);
         check($sformatf("L%0d mosi_change", l), mosi_bad[l], 0);
         check($sformatf("L%0d wide_strobe", l), wide_cnt[l], 0);
         check($sformatf("L%0d sck_after_done", l), sck_after_done[l], 0);
         check($sformatf("L%0d done_fell", l), done_fell[l], 0);
      end

      // Reset pulse in the middle of the second word on lane 0.
      rst_v[0] = 1'b1;
      @(posedge clk); #1;
      rst_v[0]  = 1'b0;
      init_v[0] = 1'b1;
      ok = 0;
      for (int c = 0; c < 5000; c++) begin
         @(posedge clk); #1;
         if (rise_cnt[0] >= HDR + 20) begin ok = 1; break; end
      end
      check("rst_mid reach_bit20", ok, 1);
      check("rst_mid strobes_before", strobe_cnt[0], 1);
      rst_v[0] = 1'b1;
      @(posedge clk); #1;
      check("rst_mid ctl", {59'd0, cs_v[0], sck_v[0], valid_v[0], busy_v[0], done_v[0]}, 64'b10000);
      rst_v[0] = 1'b0;
      @(posedge clk); #1;
      check("rst_mid no_strobe", valid_v[0], 1'b0);
      ok = 0;
      for (int c = 0; c < 5000; c++) begin
         @(posedge clk); #1;
         if (strobe_cnt[0] >= 1) begin ok = 1; break; end
      end
      check("rst_mid restart_strobe", ok, 1);
      check("rst_mid restart_word", strobe_w[0][0], 16'h1234);
      check("rst_mid restart_header", hdr_rx[0], exp_hdr(24'h000000));
      check("rst_mid restart_lag", strobe_cyc[0][0] - cs_fall_cyc[0], 2*HDR + 32 + 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
